// File: rtl/stream_demux4.sv
// rtl/stream_demux4.sv - 1:4 byte-stream demux with per-channel FIFOs; STREAM_DEMUX4_STATS_EN adds push counters
module stream_demux4_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_tdata,
    input  logic             push_tvalid,
    output logic             push_tready,
    output logic [WIDTH-1:0] pop_tdata,
    output logic             pop_tvalid,
    input  logic             pop_tready
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign push_tready = !full;
    assign pop_tvalid  = !empty;
    assign pop_tdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_tvalid && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_tdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_tready && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

module stream_demux4 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
`ifdef STREAM_DEMUX4_STATS_EN
    input  logic             io_count_clear,
    output logic [15:0]      io_count_0,
    output logic [15:0]      io_count_1,
    output logic [15:0]      io_count_2,
    output logic [15:0]      io_count_3,
`endif
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_input,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [1:0]       io_select,
    output logic [WIDTH-1:0] io_outputs_0,
    output logic [WIDTH-1:0] io_outputs_1,
    output logic [WIDTH-1:0] io_outputs_2,
    output logic [WIDTH-1:0] io_outputs_3,
    output logic             io_out_valid_0,
    output logic             io_out_valid_1,
    output logic             io_out_valid_2,
    output logic             io_out_valid_3,
    input  logic             io_out_ready_0,
    input  logic             io_out_ready_1,
    input  logic             io_out_ready_2,
    input  logic             io_out_ready_3
);
    logic [3:0]       ch_tready;
    logic [3:0]       ch_tvalid;
    logic [3:0]       ch_pop_ready;
    logic [3:0]       push_fire;
    logic [WIDTH-1:0] ch_tdata [4];

    // Ready depends only on the selected channel's occupancy, never on the consumers.
    assign io_in_ready  = ch_tready[io_select];
    assign ch_pop_ready = {io_out_ready_3, io_out_ready_2, io_out_ready_1, io_out_ready_0};

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign push_fire[k] = io_in_valid && io_in_ready && (io_select == 2'(k));

        stream_demux4_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .push_tdata  (io_input),
            .push_tvalid (push_fire[k]),
            .push_tready (ch_tready[k]),
            .pop_tdata   (ch_tdata[k]),
            .pop_tvalid  (ch_tvalid[k]),
            .pop_tready  (ch_pop_ready[k])
        );
    end

    assign io_outputs_0   = ch_tdata[0];
    assign io_outputs_1   = ch_tdata[1];
    assign io_outputs_2   = ch_tdata[2];
    assign io_outputs_3   = ch_tdata[3];
    assign io_out_valid_0 = ch_tvalid[0];
    assign io_out_valid_1 = ch_tvalid[1];
    assign io_out_valid_2 = ch_tvalid[2];
    assign io_out_valid_3 = ch_tvalid[3];

`ifdef STREAM_DEMUX4_STATS_EN
    logic [15:0] count [4];

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                count[k] <= '0;
            end
        end else if (io_count_clear) begin
            for (int k = 0; k < 4; k++) begin
                count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push_fire[k] && (count[k] != 16'hFFFF)) begin
                    count[k] <= count[k] + 16'd1;
                end
            end
        end
    end

    assign io_count_0 = count[0];
    assign io_count_1 = count[1];
    assign io_count_2 = count[2];
    assign io_count_3 = count[3];
`endif
endmodule

// File: tb/tb_stream_demux4.sv
// tb/tb_stream_demux4.sv - randomized and directed checks of stream_demux4 against a queue model
module tb_stream_demux4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [3:0] out_rdy;
    logic [7:0] out_d [4];
    logic [3:0] out_v;
`ifdef STREAM_DEMUX4_STATS_EN
    logic        count_clear;
    logic [15:0] count [4];
    int          exp_cnt [4];
`endif

    always #5 clock = ~clock;

    stream_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
`ifdef STREAM_DEMUX4_STATS_EN
        .io_count_clear (count_clear),
        .io_count_0     (count[0]),
        .io_count_1     (count[1]),
        .io_count_2     (count[2]),
        .io_count_3     (count[3]),
`endif
        .clock          (clock),
        .reset          (reset),
        .io_input       (in_data),
        .io_in_valid    (in_valid),
        .io_in_ready    (in_ready),
        .io_select      (in_sel),
        .io_outputs_0   (out_d[0]),
        .io_outputs_1   (out_d[1]),
        .io_outputs_2   (out_d[2]),
        .io_outputs_3   (out_d[3]),
        .io_out_valid_0 (out_v[0]),
        .io_out_valid_1 (out_v[1]),
        .io_out_valid_2 (out_v[2]),
        .io_out_valid_3 (out_v[3]),
        .io_out_ready_0 (out_rdy[0]),
        .io_out_ready_1 (out_rdy[1]),
        .io_out_ready_2 (out_rdy[2]),
        .io_out_ready_3 (out_rdy[3])
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: one arrival-ordered list of accepted beats tagged by channel.
    typedef struct {
        int         ch;
        logic [7:0] d;
    } beat_t;
    beat_t mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int occ(input int k);
        int n = 0;
        foreach (mq[i]) if (mq[i].ch == k) n++;
        return n;
    endfunction

    function automatic logic [7:0] head(input int k);
        foreach (mq[i]) if (mq[i].ch == k) return mq[i].d;
        return 8'h00;
    endfunction

    function automatic void pop_ch(input int k);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].ch == k) begin
                mq.delete(i);
                return;
            end
        end
    endfunction

    task automatic run_cycle(input logic v, input logic [7:0] d, input logic [1:0] s,
                             input logic [3:0] r, output logic acc);
        logic [3:0] pops;
        logic       rdy_m;
        @(negedge clock);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        out_rdy  = r;
        #1;
        rdy_m = (occ(int'(s)) < DEPTH);
        check("in_ready", 32'(in_ready), 32'(rdy_m));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid%0d", k), 32'(out_v[k]), 32'(occ(k) > 0));
            if (occ(k) > 0) check($sformatf("out_data%0d", k), 32'(out_d[k]), 32'(head(k)));
`ifdef STREAM_DEMUX4_STATS_EN
            check($sformatf("count%0d", k), 32'(count[k]), 32'(exp_cnt[k]));
`endif
            pops[k] = (occ(k) > 0) && r[k];
        end
        acc = v && rdy_m;
        @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) if (pops[k]) pop_ch(k);
        if (acc) begin
            mq.push_back('{int'(s), d});
`ifdef STREAM_DEMUX4_STATS_EN
            if (exp_cnt[int'(s)] < 16'hFFFF) exp_cnt[int'(s)]++;
`endif
        end
    endtask

    initial begin
        logic       acc;
        logic       hv;
        logic [7:0] hd;
        logic [1:0] hs;
        logic [3:0] rr;

        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_sel   = 2'd1;
        out_rdy  = 4'h0;
`ifdef STREAM_DEMUX4_STATS_EN
        count_clear = 1'b0;
        foreach (exp_cnt[k]) exp_cnt[k] = 0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_valid%0d", k), 32'(out_v[k]), 32'd0);
            check($sformatf("rst_data%0d", k), 32'(out_d[k]), 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;

        run_cycle(1'b1, 8'h5C, 2'd0, 4'hF, acc);
        check("first_acc", 32'(acc), 32'd1);

        run_cycle(1'b1, 8'hA5, 2'd2, 4'hF, acc);
        check("route_acc", 32'(acc), 32'd1);
        check("route_v2", 32'(out_v[2]), 32'd1);
        check("route_d2", 32'(out_d[2]), 32'hA5);
        check("route_others", 32'({out_v[3], out_v[1]}), 32'd0);
        run_cycle(1'b0, 8'h00, 2'd0, 4'hF, acc);
        check("route_v2_drop", 32'(out_v[2]), 32'd0);

        run_cycle(1'b1, 8'h11, 2'd1, 4'b1101, acc);
        check("bp_acc11", 32'(acc), 32'd1);
        run_cycle(1'b1, 8'h22, 2'd1, 4'b1101, acc);
        check("bp_acc22", 32'(acc), 32'd1);
        run_cycle(1'b1, 8'h7E, 2'd0, 4'b1101, acc);
        check("iso_acc", 32'(acc), 32'd1);
        check("iso_d0", 32'(out_d[0]), 32'h7E);
        check("iso_v0", 32'(out_v[0]), 32'd1);
        run_cycle(1'b1, 8'h33, 2'd1, 4'b1101, acc);
        check("bp_wait33a", 32'(acc), 32'd0);
        run_cycle(1'b1, 8'h33, 2'd1, 4'b1101, acc);
        check("bp_wait33b", 32'(acc), 32'd0);
        run_cycle(1'b1, 8'h33, 2'd1, 4'hF, acc);
        check("bp_wait33c", 32'(acc), 32'd0);
        run_cycle(1'b1, 8'h33, 2'd1, 4'hF, acc);
        check("bp_acc33", 32'(acc), 32'd1);
        repeat (3) run_cycle(1'b0, 8'h00, 2'd0, 4'hF, acc);

        run_cycle(1'b1, 8'h01, 2'd3, 4'b0111, acc);
        check("wrap_acc1", 32'(acc), 32'd1);
        for (int i = 2; i <= 10; i++) begin
            run_cycle(1'b1, 8'(i), 2'd3, 4'hF, acc);
            check("wrap_acc", 32'(acc), 32'd1);
            check("wrap_v3", 32'(out_v[3]), 32'd1);
        end
        check("wrap_occ", 32'(occ(3)), 32'd1);
        check("wrap_last", 32'(out_d[3]), 32'h0A);
        run_cycle(1'b0, 8'h00, 2'd0, 4'hF, acc);

        run_cycle(1'b1, 8'hC1, 2'd0, 4'b1110, acc);
        run_cycle(1'b1, 8'hC2, 2'd0, 4'b1110, acc);
        check("mid_full0", 32'(out_v[0]), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_rst_v0", 32'(out_v[0]), 32'd0);
        check("mid_rst_d0", 32'(out_d[0]), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
`ifdef STREAM_DEMUX4_STATS_EN
        check("mid_rst_count0", 32'(count[0]), 32'd0);
        foreach (exp_cnt[k]) exp_cnt[k] = 0;
`endif
        mq.delete();
        #2;
        reset = 1'b1;
        run_cycle(1'b0, 8'h00, 2'd0, 4'hF, acc);

        acc = 1'b1;
        hv  = 1'b0;
        hd  = 8'h00;
        hs  = 2'd0;
        for (int i = 0; i < 600; i++) begin
            if (!(hv && !acc)) begin
                hv = ($urandom_range(0, 3) != 0);
                hd = 8'($urandom);
                hs = 2'($urandom);
            end
            rr = 4'($urandom);
            run_cycle(hv, hd, hs, rr, acc);
        end
        repeat (4) run_cycle(1'b0, 8'h00, 2'd0, 4'hF, acc);
        check("drained", 32'(mq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
